// File: rtl/iob_vexriscv_pkg.sv
// Shared types and AXI constants for the VexRiscv AXI glue blocks.
package iob_vexriscv_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2
   } rd_arb_state_t;

   localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
   localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
   localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

endpackage

// File: rtl/iob_vexriscv_rr_sel.sv
// Two-input arbiter: ptr names the requester that wins a tie; grant is one-hot.
module iob_vexriscv_rr_sel (
   input  logic [1:0] req,
   input  logic       ptr,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = req;
      if (req == 2'b11) gnt = ptr ? 2'b10 : 2'b01;
   end

endmodule

// File: rtl/iob_vexriscv_axi_rd_arb.sv
// Two-requester AXI read-channel arbiter, one outstanding burst.
// Define IOB_VEXRISCV_RD_ARB_RR_EN for round-robin; default is fixed priority to requester 1.
module iob_vexriscv_axi_rd_arb
   import iob_vexriscv_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int ID_W   = 1,
   parameter int LEN_W  = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              m0_arvalid_i,
   output logic              m0_arready_o,
   input  logic [ADDR_W-1:0] m0_araddr_i,
   input  logic [ID_W-1:0]   m0_arid_i,
   input  logic [LEN_W-1:0]  m0_arlen_i,
   input  logic [2:0]        m0_arsize_i,
   input  logic [1:0]        m0_arburst_i,
   input  logic [2:0]        m0_arprot_i,
   output logic              m0_rvalid_o,
   input  logic              m0_rready_i,
   output logic [DATA_W-1:0] m0_rdata_o,
   output logic [ID_W-1:0]   m0_rid_o,
   output logic [1:0]        m0_rresp_o,
   output logic              m0_rlast_o,
   input  logic              m1_arvalid_i,
   output logic              m1_arready_o,
   input  logic [ADDR_W-1:0] m1_araddr_i,
   input  logic [ID_W-1:0]   m1_arid_i,
   input  logic [LEN_W-1:0]  m1_arlen_i,
   input  logic [2:0]        m1_arsize_i,
   input  logic [1:0]        m1_arburst_i,
   input  logic [2:0]        m1_arprot_i,
   output logic              m1_rvalid_o,
   input  logic              m1_rready_i,
   output logic [DATA_W-1:0] m1_rdata_o,
   output logic [ID_W-1:0]   m1_rid_o,
   output logic [1:0]        m1_rresp_o,
   output logic              m1_rlast_o,
   output logic              s_arvalid_o,
   input  logic              s_arready_i,
   output logic [ADDR_W-1:0] s_araddr_o,
   output logic [ID_W-1:0]   s_arid_o,
   output logic [LEN_W-1:0]  s_arlen_o,
   output logic [2:0]        s_arsize_o,
   output logic [1:0]        s_arburst_o,
   output logic [2:0]        s_arprot_o,
   input  logic              s_rvalid_i,
   output logic              s_rready_o,
   input  logic [DATA_W-1:0] s_rdata_i,
   input  logic [ID_W-1:0]   s_rid_i,
   input  logic [1:0]        s_rresp_i,
   input  logic              s_rlast_i,
   output logic              err_o
);

   rd_arb_state_t    state, state_nxt;
   logic             sel, sel_nxt;
   logic [LEN_W-1:0] cnt, cnt_nxt;
   logic             err_nxt;
   logic             ptr;
   logic [1:0]       gnt;

`ifdef IOB_VEXRISCV_RD_ARB_RR_EN
   logic done;
   assign done = (state == ST_DATA) && s_rvalid_i && s_rready_o && s_rlast_i;

   // After a finished burst the other requester gets priority.
   always_ff @(posedge clk_i) begin
      if (rst_i)     ptr <= 1'b1;
      else if (done) ptr <= ~sel;
   end
`else
   assign ptr = 1'b1;
`endif

   iob_vexriscv_rr_sel u_rr_sel (
      .req ({m1_arvalid_i, m0_arvalid_i}),
      .ptr (ptr),
      .gnt (gnt)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= ST_IDLE;
         sel   <= 1'b0;
         cnt   <= '0;
         err_o <= 1'b0;
      end else begin
         state <= state_nxt;
         sel   <= sel_nxt;
         cnt   <= cnt_nxt;
         err_o <= err_nxt;
      end
   end

   // Handshake outputs are forced low while rst_i is high, not only after the edge.
   always_comb begin
      state_nxt    = state;
      sel_nxt      = sel;
      cnt_nxt      = cnt;
      err_nxt      = 1'b0;
      s_arvalid_o  = 1'b0;
      s_rready_o   = 1'b0;
      m0_arready_o = 1'b0;
      m1_arready_o = 1'b0;
      m0_rvalid_o  = 1'b0;
      m1_rvalid_o  = 1'b0;
      if (!rst_i) begin
         case (state)
            ST_IDLE: begin
               if (m0_arvalid_i || m1_arvalid_i) begin
                  sel_nxt   = gnt[1];
                  state_nxt = ST_ADDR;
               end
            end
            ST_ADDR: begin
               s_arvalid_o = 1'b1;
               if (sel) m1_arready_o = s_arready_i;
               else     m0_arready_o = s_arready_i;
               if (s_arready_i) begin
                  cnt_nxt   = sel ? m1_arlen_i : m0_arlen_i;
                  state_nxt = ST_DATA;
               end
            end
            ST_DATA: begin
               s_rready_o = sel ? m1_rready_i : m0_rready_i;
               if (sel) m1_rvalid_o = s_rvalid_i;
               else     m0_rvalid_o = s_rvalid_i;
               if (s_rvalid_i && s_rready_o) begin
                  cnt_nxt = cnt - LEN_W'(1);
                  err_nxt = s_rlast_i != (cnt == '0);
                  if (s_rlast_i) state_nxt = ST_IDLE;
               end
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   assign s_araddr_o  = sel ? m1_araddr_i  : m0_araddr_i;
   assign s_arid_o    = sel ? m1_arid_i    : m0_arid_i;
   assign s_arlen_o   = sel ? m1_arlen_i   : m0_arlen_i;
   assign s_arsize_o  = sel ? m1_arsize_i  : m0_arsize_i;
   assign s_arburst_o = sel ? m1_arburst_i : m0_arburst_i;
   assign s_arprot_o  = sel ? m1_arprot_i  : m0_arprot_i;

   assign m0_rdata_o = s_rdata_i;
   assign m0_rid_o   = s_rid_i;
   assign m0_rresp_o = s_rresp_i;
   assign m0_rlast_o = s_rlast_i;
   assign m1_rdata_o = s_rdata_i;
   assign m1_rid_o   = s_rid_i;
   assign m1_rresp_o = s_rresp_i;
   assign m1_rlast_o = s_rlast_i;

endmodule

// File: tb/tb_iob_vexriscv_axi_rd_arb.sv
// Directed bench for iob_vexriscv_axi_rd_arb; honours IOB_VEXRISCV_RD_ARB_RR_EN.
module tb_iob_vexriscv_axi_rd_arb;
   import iob_vexriscv_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready, m0_rlast;
   logic [31:0] m0_araddr, m0_rdata;
   logic [0:0]  m0_arid, m0_rid;
   logic [7:0]  m0_arlen;
   logic [2:0]  m0_arsize, m0_arprot;
   logic [1:0]  m0_arburst, m0_rresp;
   logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready, m1_rlast;
   logic [31:0] m1_araddr, m1_rdata;
   logic [0:0]  m1_arid, m1_rid;
   logic [7:0]  m1_arlen;
   logic [2:0]  m1_arsize, m1_arprot;
   logic [1:0]  m1_arburst, m1_rresp;
   logic        s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
   logic [31:0] s_araddr, s_rdata;
   logic [0:0]  s_arid, s_rid;
   logic [7:0]  s_arlen;
   logic [2:0]  s_arsize, s_arprot;
   logic [1:0]  s_arburst, s_rresp;
   logic        err;

   int unsigned errors = 0;
   int unsigned checks = 0;

   always #5 clk = ~clk;

   iob_vexriscv_axi_rd_arb #(.ADDR_W(32), .DATA_W(32), .ID_W(1), .LEN_W(8)) dut (
      .clk_i(clk), .rst_i(rst),
      .m0_arvalid_i(m0_arvalid), .m0_arready_o(m0_arready), .m0_araddr_i(m0_araddr),
      .m0_arid_i(m0_arid), .m0_arlen_i(m0_arlen), .m0_arsize_i(m0_arsize),
      .m0_arburst_i(m0_arburst), .m0_arprot_i(m0_arprot), .m0_rvalid_o(m0_rvalid),
      .m0_rready_i(m0_rready), .m0_rdata_o(m0_rdata), .m0_rid_o(m0_rid),
      .m0_rresp_o(m0_rresp), .m0_rlast_o(m0_rlast),
      .m1_arvalid_i(m1_arvalid), .m1_arready_o(m1_arready), .m1_araddr_i(m1_araddr),
      .m1_arid_i(m1_arid), .m1_arlen_i(m1_arlen), .m1_arsize_i(m1_arsize),
      .m1_arburst_i(m1_arburst), .m1_arprot_i(m1_arprot), .m1_rvalid_o(m1_rvalid),
      .m1_rready_i(m1_rready), .m1_rdata_o(m1_rdata), .m1_rid_o(m1_rid),
      .m1_rresp_o(m1_rresp), .m1_rlast_o(m1_rlast),
      .s_arvalid_o(s_arvalid), .s_arready_i(s_arready), .s_araddr_o(s_araddr),
      .s_arid_o(s_arid), .s_arlen_o(s_arlen), .s_arsize_o(s_arsize),
      .s_arburst_o(s_arburst), .s_arprot_o(s_arprot), .s_rvalid_i(s_rvalid),
      .s_rready_o(s_rready), .s_rdata_i(s_rdata), .s_rid_i(s_rid),
      .s_rresp_i(s_rresp), .s_rlast_i(s_rlast), .err_o(err)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_quiet(input string tag);
      check(tag, {s_arvalid, s_rready, m0_arready, m1_arready, m0_rvalid, m1_rvalid}, 6'b0);
   endtask

   task automatic set_req(input int m, input logic [7:0] len, input logic [31:0] addr);
      if (m == 1) begin
         m1_arvalid = 1'b1; m1_arlen = len; m1_araddr = addr;
      end else begin
         m0_arvalid = 1'b1; m0_arlen = len; m0_araddr = addr;
      end
   endtask

   // Called in IDLE with the request(s) already raised; ends one cycle into DATA.
   task automatic ar_phase(input int m, input logic [7:0] len, input logic [31:0] addr, input int stall);
      check("ar_idle", s_arvalid, 1'b0);
      check("arrdy_idle", {m1_arready, m0_arready}, 2'b00);
      tick();
      check("err_clr", err, 1'b0);
      for (int i = 0; i <= stall; i++) begin
         check("s_arvalid", s_arvalid, 1'b1);
         check("s_araddr", s_araddr, addr);
         check("s_arlen", s_arlen, len);
         check("s_arid", s_arid, (m == 1) ? 1'b1 : 1'b0);
         if (i < stall) begin
            check("arrdy_stall", {m1_arready, m0_arready}, 2'b00);
            tick();
         end
      end
      s_arready = 1'b1;
      #1;
      check("arready", {m1_arready, m0_arready}, (m == 1) ? 2'b10 : 2'b01);
      tick();
      s_arready = 1'b0;
      if (m == 1) m1_arvalid = 1'b0;
      else        m0_arvalid = 1'b0;
   endtask

   task automatic beat(input int m, input logic [31:0] d, input logic last);
      s_rvalid = 1'b1; s_rdata = d; s_rlast = last;
      if (m == 1) m1_rready = 1'b1; else m0_rready = 1'b1;
      #1;
      check("s_rready", s_rready, 1'b1);
      check("rvalid_pair", {m1_rvalid, m0_rvalid}, (m == 1) ? 2'b10 : 2'b01);
      check("rdata", (m == 1) ? m1_rdata : m0_rdata, d);
      check("rlast", (m == 1) ? m1_rlast : m0_rlast, last);
      check("arrdy_data", {m1_arready, m0_arready}, 2'b00);
      tick();
      s_rvalid = 1'b0; s_rlast = 1'b0;
   endtask

   task automatic end_burst(input logic exp_err);
      check("err", err, exp_err);
      check_quiet("idle_quiet");
   endtask

   initial begin
      rst = 1'b1;
      m0_arvalid = 0; m0_araddr = 0; m0_arid = 1'b0; m0_arlen = 0; m0_arsize = 3'd2;
      m0_arburst = AXI_BURST_INCR; m0_arprot = 3'd4; m0_rready = 1'b1;
      m1_arvalid = 0; m1_araddr = 0; m1_arid = 1'b1; m1_arlen = 0; m1_arsize = 3'd2;
      m1_arburst = AXI_BURST_INCR; m1_arprot = 3'd0; m1_rready = 1'b1;
      s_arready = 0; s_rvalid = 0; s_rdata = 0; s_rid = 0; s_rresp = AXI_RESP_OKAY; s_rlast = 0;
      tick();
      check_quiet("reset_quiet");
      check("reset_err", err, 1'b0);
      rst = 1'b0;
      tick();

      // m0 alone, 4-beat burst
      set_req(0, 8'd3, 32'h0000_1000);
      ar_phase(0, 8'd3, 32'h0000_1000, 0);
      for (int i = 0; i < 4; i++) beat(0, 32'hA0 + i, i == 3);
      end_burst(1'b0);

      // simultaneous requests: m1 first, then policy decides
      set_req(0, 8'd1, 32'h0000_2000);
      set_req(1, 8'd0, 32'h0000_2100);
      ar_phase(1, 8'd0, 32'h0000_2100, 0);
      beat(1, 32'hB0, 1'b1);
      end_burst(1'b0);
      set_req(1, 8'd0, 32'h0000_2200);
`ifdef IOB_VEXRISCV_RD_ARB_RR_EN
      ar_phase(0, 8'd1, 32'h0000_2000, 0);
      beat(0, 32'hC0, 1'b0);
      beat(0, 32'hC1, 1'b1);
      end_burst(1'b0);
      ar_phase(1, 8'd0, 32'h0000_2200, 0);
      beat(1, 32'hC2, 1'b1);
      end_burst(1'b0);
`else
      ar_phase(1, 8'd0, 32'h0000_2200, 0);
      beat(1, 32'hC2, 1'b1);
      end_burst(1'b0);
      ar_phase(0, 8'd1, 32'h0000_2000, 0);
      beat(0, 32'hC0, 1'b0);
      beat(0, 32'hC1, 1'b1);
      end_burst(1'b0);
`endif

      // early rlast on the third beat of a 4-beat burst
      set_req(0, 8'd3, 32'h0000_3000);
      ar_phase(0, 8'd3, 32'h0000_3000, 0);
      beat(0, 32'hD0, 1'b0);
      beat(0, 32'hD1, 1'b0);
      beat(0, 32'hD2, 1'b1);
      end_burst(1'b1);

      // single beat with arready stalled 5 cycles
      set_req(0, 8'd0, 32'h0000_4000);
      ar_phase(0, 8'd0, 32'h0000_4000, 5);
      beat(0, 32'hE0, 1'b1);
      end_burst(1'b0);

      // rready back-pressure mid-burst on m1
      set_req(1, 8'd3, 32'h0000_5000);
      ar_phase(1, 8'd3, 32'h0000_5000, 0);
      beat(1, 32'hF0, 1'b0);
      s_rvalid = 1'b1; s_rdata = 32'hF1; m1_rready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("bp_s_rready", s_rready, 1'b0);
         check("bp_rvalid", m1_rvalid, 1'b1);
         check("bp_rdata", m1_rdata, 32'hF1);
         tick();
      end
      beat(1, 32'hF1, 1'b0);
      beat(1, 32'hF2, 1'b0);
      beat(1, 32'hF3, 1'b1);
      end_burst(1'b0);

      // reset during the second beat abandons the burst
      set_req(1, 8'd3, 32'h0000_6000);
      ar_phase(1, 8'd3, 32'h0000_6000, 0);
      beat(1, 32'h60, 1'b0);
      s_rvalid = 1'b1; s_rdata = 32'h61; rst = 1'b1;
      #1;
      check_quiet("in_reset_quiet");
      tick();
      rst = 1'b0; s_rvalid = 1'b0;
      #1;
      check_quiet("post_reset_quiet");
      check("post_reset_err", err, 1'b0);
      set_req(1, 8'd1, 32'h0000_7000);
      ar_phase(1, 8'd1, 32'h0000_7000, 0);
      beat(1, 32'h70, 1'b0);
      beat(1, 32'h71, 1'b1);
      end_burst(1'b0);
      tick();
      check("err_final", err, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/iob_vexriscv_axi_rd_arb.md
IOB_VEXRISCV_AXI_RD_ARB -- requirements
Module: iob_vexriscv_axi_rd_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, AXI address width.
REQ-002 SHALL have parameter DATA_W, default 32, AXI data width.
REQ-003 SHALL have parameter ID_W, default 1, AXI ID width.
REQ-004 SHALL have parameter LEN_W, default 8, AXI burst-length width.
REQ-005 SHALL have port clk_i, input, 1, the only clock; one clock domain, rising edge.
REQ-006 SHALL have port rst_i, input, 1, reset; synchronous, active-high.
REQ-007 SHALL have ports m0_arvalid_i/m0_arready_o, in/out, 1/1, requester 0 (iBus) AR handshake.
REQ-008 SHALL have ports m0_araddr_i/m0_arid_i/m0_arlen_i, input, ADDR_W/ID_W/LEN_W, requester 0 AR payload.
REQ-009 SHALL have ports m0_arsize_i/m0_arburst_i/m0_arprot_i, input, 3/2/3, requester 0 AR attributes.
REQ-010 SHALL have ports m0_rvalid_o/m0_rready_i, out/in, 1/1, requester 0 R handshake.
REQ-011 SHALL have ports m0_rdata_o/m0_rid_o/m0_rresp_o/m0_rlast_o, output, DATA_W/ID_W/2/1, requester 0 R payload.
REQ-012 SHALL have an identical m1_* port set (REQ-007..011) for requester 1 (dBus).
REQ-013 SHALL have ports s_arvalid_o/s_arready_i plus s_ar* payload and attributes, out/in, widths as REQ-008/009, shared AXI read master.
REQ-014 SHALL have ports s_rvalid_i/s_rready_o plus s_rdata_i/s_rid_i/s_rresp_i/s_rlast_i, in/out, widths as REQ-011, shared AXI read data.
REQ-015 SHALL have port err_o, output, 1, one-cycle pulse on a burst-length mismatch.

Function
REQ-016 SHALL implement the FSM states IDLE, ADDR and DATA, with one outstanding transaction at most.
REQ-017 In IDLE, when any mN_arvalid_i=1, SHALL register the grant (sel) and go to ADDR next cycle; the latency from arvalid to s_arvalid_o SHALL be 1 cycle.
REQ-018 In ADDR, SHALL drive s_arvalid_o=1 with the payload of sel, and SHALL drive mSel_arready_o=s_arready_i combinationally; the other arready SHALL be 0.
REQ-019 In ADDR, on s_arvalid_o&s_arready_i SHALL load beat counter=arlen and go to DATA.
REQ-020 In DATA, SHALL route s_r* to mSel_r*, drive s_rready_o=mSel_rready_i, and hold the non-selected rvalid at 0.
REQ-021 The counter SHALL decrement on each R handshake.
REQ-022 In DATA, on an R handshake with s_rlast_i=1, SHALL return to IDLE and update the priority pointer.
REQ-023 err_o SHALL pulse if s_rlast_i=1 while count!=0, or s_rlast_i=0 while count==0; the FSM SHALL still follow s_rlast_i.
REQ-024 A requester arvalid arriving during ADDR/DATA SHALL wait; no arready SHALL be given outside ADDR.
REQ-025 When both requesters assert arvalid in the same IDLE cycle, the grant SHALL follow the REQ-032/033 policy.
REQ-026 arlen=0 (single beat) SHALL work with count==0 and rlast on the first beat.

Reset
REQ-027 On rst_i=1 at a clock edge, the block SHALL enter IDLE.
REQ-028 Reset SHALL clear sel, the counter and err_o.
REQ-029 Reset SHALL set the priority pointer to requester 1.
REQ-030 During and after reset, all *valid/*ready outputs SHALL be 0.
REQ-031 A reset mid-transaction SHALL abandon the transaction; the downstream slave SHALL be reset concurrently.

Configuration
REQ-032 With macro IOB_VEXRISCV_RD_ARB_RR_EN defined, the arbiter SHALL use round-robin: after a completed burst, the other requester has priority.
REQ-033 Without IOB_VEXRISCV_RD_ARB_RR_EN, the arbiter SHALL use fixed priority with requester 1 (dBus) always winning ties, and the pointer register SHALL be absent.

Structure
REQ-034 The FSM state encodings and the AXI burst/resp constants SHALL reside in the shared package iob_vexriscv_pkg.
REQ-035 The grant logic SHALL be a sub-module iob_vexriscv_rr_sel (2-input arbiter, pointer in, one-hot grant out).

Verification
REQ-036 Only m0 requests arlen=3 → s_arvalid_o one cycle later with m0 payload; m0 receives 4 beats; m1_rvalid_o stays 0; FSM returns to IDLE.
REQ-037 m0 and m1 request simultaneously after reset → m1 granted first; with RR_EN, m0 is granted next; without it, a re-asserted m1 is granted again.
REQ-038 Slave asserts rlast on beat 2 of arlen=3 → err_o=1 for one cycle; FSM returns to IDLE.
REQ-039 m0 requests arlen=0 while s_arready_i is held low for 5 cycles → s_arvalid_o and the payload stay stable; single beat delivered; no err_o.
REQ-040 rst_i pulsed during DATA beat 1 → next cycle all valid/ready outputs are 0 and FSM is in IDLE; a new m1 request then completes normally.
REQ-041 m1 rready_i held low for 3 cycles mid-burst → s_rready_o stays 0, the counter holds, and no beat is lost.
